// File: rtl/riscv_boot_loader_if.sv
// Bundle carrying the host byte stream and the instruction-memory write port of the
// boot loader. The loader connects through the master modport; the host link model and
// the instruction memory connect through the slave modport.
interface riscv_boot_loader_if #(
   parameter int ADDR_W = 10
);
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic              rx_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;

   modport master (
      input  rx_data,
      input  rx_valid,
      output rx_ready,
      output imem_we,
      output imem_addr,
      output imem_wdata
   );

   modport slave (
      output rx_data,
      output rx_valid,
      input  rx_ready,
      input  imem_we,
      input  imem_addr,
      input  imem_wdata
   );
endinterface

// File: rtl/riscv_boot_loader.sv
// Boot loader sitting upstream of the RISC-V core. Receives an image as a byte stream
// (two length bytes giving the word count N, then 4*N bytes, LSB first), packs the bytes
// into 32-bit little-endian words, writes them to instruction memory and keeps the core
// in reset until the whole image is in place. A reload pulse in RUN or ERR re-arms it.
// Optional feature: define BOOT_CHECKSUM_EN to require a trailing mod-256 checksum byte
// covering every preceding image byte, length bytes included.
module riscv_boot_loader #(
   parameter int ADDR_W    = 10,
   parameter int BASE_ADDR = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   riscv_boot_loader_if.master  bus,
   input  logic                 reload,
   output logic                 core_rst,
   output logic                 done,
   output logic                 error
);

   localparam int MAX_WORDS = 2 ** ADDR_W;

   typedef enum logic [2:0] {
      LEN_LO,
      LEN_HI,
      DATA,
      CHK,
      RUN,
      ERR
   } state_t;

   state_t state;
   state_t next_state;

   logic [7:0]  len_lo;
   logic [15:0] len;
   logic [15:0] len_full;
   logic [1:0]  byte_lane;
   logic [23:0] word_buf;
   logic [15:0] word_idx;
   logic        accept;
   logic        last_word;
   logic        rearm;

`ifdef BOOT_CHECKSUM_EN
   logic [7:0]  sum;
`endif

   assign accept    = bus.rx_valid & bus.rx_ready;
   assign len_full  = {bus.rx_data, len_lo};
   assign last_word = ((word_idx + 16'd1) == len);
   assign rearm     = reload && ((state == RUN) || (state == ERR));

   // Status outputs are pure functions of the state; byte intake pauses while a word is written
   always_comb begin
      bus.rx_ready = 1'b0;
      core_rst     = 1'b1;
      done         = 1'b0;
      error        = 1'b0;
      case (state)
         LEN_LO, LEN_HI, DATA, CHK: bus.rx_ready = ~bus.imem_we;
         RUN: begin
            core_rst = 1'b0;
            done     = 1'b1;
         end
         ERR:     error = 1'b1;
         default: ;
      endcase
   end

   // Next-state logic: header parse, data phase ending on the last word's write, restart on reload
   always_comb begin
      next_state = state;
      case (state)
         LEN_LO: begin
            if (accept) next_state = LEN_HI;
         end
         LEN_HI: begin
            if (accept) begin
               if (len_full == 16'd0) begin
`ifdef BOOT_CHECKSUM_EN
                  next_state = CHK;
`else
                  next_state = RUN;
`endif
               end else if (32'(len_full) > 32'(MAX_WORDS)) begin
                  next_state = ERR;
               end else begin
                  next_state = DATA;
               end
            end
         end
         DATA: begin
            if (bus.imem_we && last_word) begin
`ifdef BOOT_CHECKSUM_EN
               next_state = CHK;
`else
               next_state = RUN;
`endif
            end
         end
`ifdef BOOT_CHECKSUM_EN
         CHK: begin
            if (accept) next_state = (bus.rx_data == sum) ? RUN : ERR;
         end
`endif
         RUN, ERR: begin
            if (reload) next_state = LEN_LO;
         end
         default: next_state = LEN_LO;
      endcase
   end

   // State register; an asynchronous reset discards any load in progress
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= LEN_LO;
      end else begin
         state <= next_state;
      end
   end

   // Datapath: length capture, byte-lane packing, one-cycle write strobe and word counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         len_lo         <= 8'd0;
         len            <= 16'd0;
         byte_lane      <= 2'd0;
         word_buf       <= 24'd0;
         word_idx       <= 16'd0;
         bus.imem_we    <= 1'b0;
         bus.imem_addr  <= ADDR_W'(BASE_ADDR);
         bus.imem_wdata <= 32'd0;
`ifdef BOOT_CHECKSUM_EN
         sum            <= 8'd0;
`endif
      end else if (rearm) begin
         len_lo         <= 8'd0;
         len            <= 16'd0;
         byte_lane      <= 2'd0;
         word_buf       <= 24'd0;
         word_idx       <= 16'd0;
         bus.imem_we    <= 1'b0;
         bus.imem_addr  <= ADDR_W'(BASE_ADDR);
         bus.imem_wdata <= 32'd0;
`ifdef BOOT_CHECKSUM_EN
         sum            <= 8'd0;
`endif
      end else begin
         bus.imem_we <= 1'b0;
         if (bus.imem_we) begin
            word_idx <= word_idx + 16'd1;
         end
         if (accept) begin
`ifdef BOOT_CHECKSUM_EN
            sum <= sum + bus.rx_data;
`endif
            case (state)
               LEN_LO: len_lo <= bus.rx_data;
               LEN_HI: len    <= len_full;
               DATA: begin
                  byte_lane <= byte_lane + 2'd1;
                  if (byte_lane == 2'd3) begin
                     bus.imem_we    <= 1'b1;
                     bus.imem_wdata <= {bus.rx_data, word_buf};
                     bus.imem_addr  <= ADDR_W'(BASE_ADDR) + ADDR_W'(word_idx);
                  end else begin
                     word_buf[8*byte_lane +: 8] <= bus.rx_data;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_riscv_boot_loader.sv
// Self-checking bench for riscv_boot_loader. Stimulus builds whole images from word lists,
// pushes the expected memory writes into a scoreboard queue and streams the bytes with
// optional random gaps; an independent monitor pops and compares on every write strobe.
module tb_riscv_boot_loader;

   localparam int ADDR_W    = 10;
   localparam int BASE_ADDR = 0;
   localparam int MAX_WORDS = 2 ** ADDR_W;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
   } wr_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic reload = 1'b0;
   logic core_rst, done, error;

   int checks = 0;
   int failures = 0;
   wr_t exp_q[$];
   logic [31:0] img[$];
   logic prev_we = 1'b0;

   riscv_boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

   riscv_boot_loader #(
      .ADDR_W   (ADDR_W),
      .BASE_ADDR(BASE_ADDR)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus),
      .reload  (reload),
      .core_rst(core_rst),
      .done    (done),
      .error   (error)
   );

   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports any difference
   function automatic void check_output(input string name, input logic [31:0] actual,
                                        input logic [31:0] required);
      checks++;
      if (actual !== required) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, required);
      end
   endfunction

   // Monitor: every write strobe must match the oldest outstanding expected write
   always @(negedge clk) begin : monitor
      wr_t e;
      if (rst && bus.imem_we) begin
         check_output("imem_we_single_cycle", 32'(prev_we), 32'd0);
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%08h, expected no write",
                     bus.imem_addr, bus.imem_wdata);
         end else begin
            e = exp_q.pop_front();
            check_output("imem_addr", 32'(bus.imem_addr), 32'(e.addr));
            check_output("imem_wdata", bus.imem_wdata, e.data);
         end
      end
      prev_we = bus.imem_we;
   end

   // Present one byte and hold it until the loader is ready; transfer happens at the next edge
   task automatic apply_stimulus(input logic [7:0] b, input bit gaps);
      int waited;
      waited = 0;
      @(negedge clk);
      if (gaps && ($urandom_range(0, 2) == 0)) begin
         bus.rx_valid = 1'b0;
         repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      bus.rx_valid = 1'b1;
      bus.rx_data  = b;
      while (!bus.rx_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (waited >= 50) begin
         checks++;
         failures++;
         $display("[TB] FAIL rx_ready_timeout: got rx_ready=0 for 50 cycles, expected 1");
      end
   endtask

   // Send the image held in img[] and check that the core is released once it has landed
   task automatic load_image(input bit gaps);
      int n;
      logic [7:0] sum;
      logic [31:0] w;
      n   = img.size();
      sum = 8'd0;
      for (int i = 0; i < n; i++) begin
         exp_q.push_back('{addr: ADDR_W'(BASE_ADDR + i), data: img[i]});
      end
      apply_stimulus(8'(n), gaps);
      sum = sum + 8'(n);
      apply_stimulus(8'(n >> 8), gaps);
      sum = sum + 8'(n >> 8);
      for (int i = 0; i < n; i++) begin
         w = img[i];
         for (int k = 0; k < 4; k++) begin
            apply_stimulus(w[8*k +: 8], gaps);
            sum = sum + w[8*k +: 8];
         end
      end
`ifdef BOOT_CHECKSUM_EN
      apply_stimulus(sum, gaps);
`endif
      @(negedge clk);
      bus.rx_valid = 1'b0;
`ifndef BOOT_CHECKSUM_EN
      if (n > 0) begin
         check_output("last_write_strobe", 32'(bus.imem_we), 32'd1);
         check_output("core_rst_held_at_last_write", 32'(core_rst), 32'd1);
         @(negedge clk);
      end
`endif
      check_output("done_after_load", 32'(done), 32'd1);
      check_output("core_rst_released", 32'(core_rst), 32'd0);
      check_output("error_after_load", 32'(error), 32'd0);
      check_output("rx_ready_in_run", 32'(bus.rx_ready), 32'd0);
   endtask

   // Reload pulse: loader returns to header parse with the core held in reset
   task automatic pulse_reload();
      @(negedge clk);
      reload = 1'b1;
      @(negedge clk);
      reload = 1'b0;
      check_output("reload_core_rst", 32'(core_rst), 32'd1);
      check_output("reload_done", 32'(done), 32'd0);
      check_output("reload_error", 32'(error), 32'd0);
      check_output("reload_rx_ready", 32'(bus.rx_ready), 32'd1);
   endtask

   // Oversized length: loader must fault, refuse bytes and keep the core in reset
   task automatic expect_len_error(input logic [15:0] n);
      apply_stimulus(n[7:0], 1'b0);
      apply_stimulus(n[15:8], 1'b0);
      bus.rx_data = 8'hA5;
      repeat (3) begin
         @(negedge clk);
         check_output("err_flag", 32'(error), 32'd1);
         check_output("err_rx_ready", 32'(bus.rx_ready), 32'd0);
         check_output("err_core_rst", 32'(core_rst), 32'd1);
      end
      bus.rx_valid = 1'b0;
   endtask

   // Watchdog so a stuck DUT still ends the run
   initial begin
      #900000;
      $display("[TB] FAIL watchdog: got simulation still running, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main sequence
   initial begin
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      repeat (3) @(negedge clk);
      check_output("reset_core_rst", 32'(core_rst), 32'd1);
      check_output("reset_imem_we", 32'(bus.imem_we), 32'd0);
      check_output("reset_imem_addr", 32'(bus.imem_addr), 32'(BASE_ADDR));
      check_output("reset_imem_wdata", bus.imem_wdata, 32'd0);
      check_output("reset_done", 32'(done), 32'd0);
      check_output("reset_error", 32'(error), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      check_output("post_reset_rx_ready", 32'(bus.rx_ready), 32'd1);

      // Reset asserted in the middle of the data phase
      apply_stimulus(8'h02, 1'b0);
      apply_stimulus(8'h00, 1'b0);
      apply_stimulus(8'h13, 1'b0);
      apply_stimulus(8'h00, 1'b0);
      @(negedge clk);
      bus.rx_valid = 1'b0;
      rst = 1'b0;
      #1;
      check_output("midload_reset_core_rst", 32'(core_rst), 32'd1);
      check_output("midload_reset_imem_we", 32'(bus.imem_we), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_output("midload_release_rx_ready", 32'(bus.rx_ready), 32'd1);
      check_output("midload_release_done", 32'(done), 32'd0);

      // Two-instruction reference image
      img = {};
      img.push_back(32'h00000013);
      img.push_back(32'h00100093);
      load_image(1'b0);

      // Reload from RUN with a one-word image
      pulse_reload();
      img = {};
      img.push_back(32'hDEADBEEF);
      load_image(1'b0);

      // Three random words with random valid gaps
      pulse_reload();
      img = {};
      for (int i = 0; i < 3; i++) img.push_back($urandom());
      load_image(1'b1);

      // Empty image goes straight to running
      pulse_reload();
      img = {};
      load_image(1'b0);

      // Random sizes with gaps
      for (int t = 0; t < 4; t++) begin
         pulse_reload();
         img = {};
         for (int i = 0; i < int'($urandom_range(1, 6)); i++) img.push_back($urandom());
         load_image(1'b1);
      end

      // Length far above capacity, then one just above it
      pulse_reload();
      expect_len_error(16'hFFFF);
      pulse_reload();
      expect_len_error(16'(MAX_WORDS + 1));

      // Exactly full capacity is accepted
      pulse_reload();
      img = {};
      for (int i = 0; i < MAX_WORDS; i++) img.push_back($urandom());
      load_image(1'b0);

`ifdef BOOT_CHECKSUM_EN
      // Good checksum trailer, then a wrong one
      pulse_reload();
      img = {};
      img.push_back(32'h04030201);
      load_image(1'b0);
      pulse_reload();
      exp_q.push_back('{addr: ADDR_W'(BASE_ADDR), data: 32'h04030201});
      apply_stimulus(8'h01, 1'b0);
      apply_stimulus(8'h00, 1'b0);
      apply_stimulus(8'h01, 1'b0);
      apply_stimulus(8'h02, 1'b0);
      apply_stimulus(8'h03, 1'b0);
      apply_stimulus(8'h04, 1'b0);
      apply_stimulus(8'h0C, 1'b0);
      @(negedge clk);
      bus.rx_valid = 1'b0;
      check_output("bad_checksum_error", 32'(error), 32'd1);
      check_output("bad_checksum_core_rst", 32'(core_rst), 32'd1);
      check_output("bad_checksum_done", 32'(done), 32'd0);
`endif

      repeat (3) @(negedge clk);
      check_output("pending_writes", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
